vector_mac_stream: RTL and testbench
====================================

Name: vector_mac_stream

Overview:
- Pipelined, parametrised dot-product engine; successor to the fixed 4x4-bit combinational vector unit.
- Accepts LANES element pairs per beat over a valid/ready stream and multiplies them lane-wise.
- Reduces the products through a registered adder tree and accumulates across beats until a beat flagged last.
- Emits one held result per vector, with a beat count and an overflow flag. Sits between operand buffers and the downstream result consumer.

Parameters:
- LANES, 4, element pairs per beat; power of two, 1..16.
- W, 4, element width in bits.
- ACC_W, 16, accumulator/result width; must be >= 2*W+clog2(LANES).
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and result.
- CNT_W, 8, width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  engine can accept a beat.
- in_a  in  LANES*W  packed operand A, lane 0 in bits [W-1:0].
- in_b  in  LANES*W  packed operand B, same packing.
- in_last  in  1  final beat of the current vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  dot product of the completed vector.
- out_beats  out  CNT_W  beats in the vector, saturating at all-ones.
- out_ovf  out  1  accumulator overflowed during the vector.

Behaviour:
- Reset: clk and rst follow the decision above (one clock, rst asynchronous active-high). While rst is high, all pipeline valids, accumulator, counter, sticky overflow and output registers are 0. So out_valid=0, out_sum=0, out_beats=0, out_ovf=0, in_ready=1 after reset.
- Reset mid-vector discards the partial accumulation and any in-flight beats; no result is emitted for them.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall. When stall is high, every pipeline stage holds.
- A beat is accepted on an edge where in_valid && in_ready.
- Stage 1 (edge of acceptance): register the LANES products, each 2*W bits, sign- or zero-extended per SIGNED. Also register the last flag and a valid bit.
- Stage 2: register the adder-tree sum, 2*W+clog2(LANES) bits, with the sign-correct extension. Carry valid and last along.
- Stage 3, when valid:
  - next = acc + sum, extended to ACC_W; count = beats+1, saturating.
  - Set the sticky ovf bit if the add overflows: carry-out in unsigned mode, sign overflow in signed mode.
  - If last: load out_sum=next, out_beats=count, out_ovf=ovf|new_ovf; set out_valid; clear acc, beats and ovf to 0.
  - Otherwise: acc=next and beats=count.
- The accumulator wraps modulo 2^ACC_W; it never saturates.
- Latency: a last beat accepted at edge E0 gives out_valid high after edge E2, i.e. 3 cycles from the sampling cycle, when there is no stall.
- Throughput: one beat per cycle.
- Output: out_valid stays high and out_sum, out_beats and out_ovf stay stable until out_ready is seen high.
- On the edge where out_valid && out_ready, a new result from stage 3 may load in the same edge, so results can be back-to-back.
- Single-beat vector (in_last on the first beat): result = that beat's dot product, out_beats=1.
- in_last with in_valid low is ignored. in_a, in_b and in_last are don't-care when in_valid is low.
- No combinational path from in_valid to in_ready. out_ready reaches in_ready combinationally, which is accepted.

Decomposition:
- Package vector_pkg holds:
  - clog2 function.
  - Derived constants PROD_W=2*W and TREE_W=2*W+clog2(LANES), as localparam functions of W and LANES.
  - Lane slicing helper.
- One sub-module, lane_mul_tree: takes LANES packed pairs, produces registered products and a registered tree sum (stages 1–2), parametrised by LANES, W and SIGNED, with a hold enable.
- Top vector_mac_stream owns the handshake, the accumulator stage, the counter, overflow and the output register.

Test Plan:
- Single beat, defaults: a=(1,2,3,4), b=(5,6,7,8), last=1, out_ready=1 -> out_sum=70, out_beats=1, out_ovf=0, out_valid exactly 3 cycles after acceptance.
- Two-beat vector: beat0 all a=b=15, beat1 a=(1,1,1,1), b=(2,2,2,2), last -> out_sum=908, out_beats=2. The next vector starts from 0.
- Backpressure: out_ready=0 with 3 back-to-back single-beat vectors of sums 10, 20, 30 -> in_ready drops and out_sum holds at 10. Release out_ready -> 10, 20, 30 delivered in order, none lost or duplicated.
- Overflow: 73 beats of all-15 (900 each, total 65700), last on beat 73 -> out_sum=164 (65700 mod 65536), out_ovf=1, out_beats=73. The following vector shows out_ovf=0.
- SIGNED=1: a=(-8,-8,-8,-8), b=(-8,-8,-8,-8) -> out_sum=256. a=(-8,7,0,1), b=(7,7,3,-1) -> out_sum=-8 (0xFFF8).
- Reset mid-vector: 2 beats accepted without last, assert rst for 1 cycle, then one beat a=b=(1,1,1,1) last -> out_sum=4, out_beats=1, and no spurious out_valid during or after the reset.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared sizing helpers for the streaming dot-product engine.
// Widths are derived from W and LANES so every stage agrees on them.
package vector_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Product width plus enough headroom to sum every lane without loss.
  function automatic int tree_w(input int w, input int lanes);
    return 2 * w + clog2(lanes);
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/vector_mac_stream_lane_mul_tree.sv
// Stages 1-2 of the engine: registered lane products, then a registered sum
// of all lanes. Both stages freeze while en is low.
module lane_mul_tree
  import vector_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int W      = 4,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [LANES*W-1:0]            a,
  input  logic [LANES*W-1:0]            b,
  output logic                          sum_valid,
  output logic                          sum_last,
  output logic [tree_w(W, LANES)-1:0]   sum
);

  localparam int PROD_W = prod_w(W);
  localparam int TREE_W = tree_w(W, LANES);

  logic [PROD_W-1:0] prod_next [LANES];
  logic [PROD_W-1:0] prod_reg  [LANES];
  logic              p_valid_reg;
  logic              p_last_reg;
  logic [TREE_W-1:0] tree_next;

  // Operands are widened to the product width first; the truncated product
  // of the widened values equals the exact signed or unsigned product.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]      la;
    logic [W-1:0]      lb;
    logic [PROD_W-1:0] xa;
    logic [PROD_W-1:0] xb;
    assign la = a[lane_lsb(gi, W) +: W];
    assign lb = b[lane_lsb(gi, W) +: W];
    assign xa = (SIGNED != 0) ? {{W{la[W-1]}}, la} : {{W{1'b0}}, la};
    assign xb = (SIGNED != 0) ? {{W{lb[W-1]}}, lb} : {{W{1'b0}}, lb};
    assign prod_next[gi] = xa * xb;
  end

  always_comb begin
    logic [TREE_W-1:0] e;
    tree_next = '0;
    for (int i = 0; i < LANES; i++) begin
      e = (SIGNED != 0 && prod_reg[i][PROD_W-1]) ? '1 : '0;
      e[PROD_W-1:0] = prod_reg[i];
      tree_next = tree_next + e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_reg <= 1'b0;
      p_last_reg  <= 1'b0;
      sum_valid   <= 1'b0;
      sum_last    <= 1'b0;
      sum         <= '0;
      for (int i = 0; i < LANES; i++) prod_reg[i] <= '0;
    end else if (en) begin
      p_valid_reg <= in_valid;
      p_last_reg  <= in_last;
      sum_valid   <= p_valid_reg;
      sum_last    <= p_last_reg;
      sum         <= tree_next;
      for (int i = 0; i < LANES; i++) prod_reg[i] <= prod_next[i];
    end
  end

endmodule

// File: rtl/vector_mac_stream.sv
// Streaming dot-product engine: multiply/reduce pipeline, cross-beat
// accumulator with sticky overflow, and a held result register.
module vector_mac_stream
  import vector_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int W      = 4,
  parameter int ACC_W  = 16,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_beats,
  output logic               out_ovf
);

  localparam int TREE_W = tree_w(W, LANES);

  logic              stall;
  logic              advance;
  logic              accept;
  logic              sum_valid;
  logic              sum_last;
  logic [TREE_W-1:0] sum;

  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  beats_reg;
  logic              ovf_reg;
  logic [ACC_W-1:0]  sum_ext;
  logic [ACC_W:0]    wide;
  logic [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]  count_next;
  logic              add_ovf;

  // A held result blocks the whole pipeline, so nothing in flight is lost.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  lane_mul_tree #(
    .LANES  (LANES),
    .W      (W),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (advance),
    .in_valid  (accept),
    .in_last   (in_last),
    .a         (in_a),
    .b         (in_b),
    .sum_valid (sum_valid),
    .sum_last  (sum_last),
    .sum       (sum)
  );

  always_comb begin
    sum_ext = (SIGNED != 0 && sum[TREE_W-1]) ? '1 : '0;
    sum_ext[TREE_W-1:0] = sum;
    wide       = {1'b0, acc_reg} + {1'b0, sum_ext};
    acc_next   = wide[ACC_W-1:0];
    count_next = (&beats_reg) ? beats_reg : beats_reg + CNT_W'(1);
    // Signed overflow: equal operand signs but the result sign differs.
    add_ovf    = (SIGNED != 0)
               ? ((acc_reg[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_next[ACC_W-1] != acc_reg[ACC_W-1]))
               : wide[ACC_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      beats_reg <= '0;
      ovf_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (advance && sum_valid) begin
        if (sum_last) begin
          out_sum   <= acc_next;
          out_beats <= count_next;
          out_ovf   <= ovf_reg | add_ovf;
          out_valid <= 1'b1;
          acc_reg   <= '0;
          beats_reg <= '0;
          ovf_reg   <= 1'b0;
        end else begin
          acc_reg   <= acc_next;
          beats_reg <= count_next;
          ovf_reg   <= ovf_reg | add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_stream.sv
// Bench for vector_mac_stream: unsigned and signed instances share one input
// stream and are checked against a plain-arithmetic dot-product model.
module tb_vector_mac_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        out_ready;
  logic        in_ready_u, in_ready_s;
  logic        out_valid_u, out_valid_s;
  logic [15:0] out_sum_u, out_sum_s;
  logic [7:0]  out_beats_u, out_beats_s;
  logic        out_ovf_u, out_ovf_s;

  int checks = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  beats;
    logic        ovf;
  } res_t;

  res_t q_u[$];
  res_t q_s[$];

  always #5 clk = ~clk;

  vector_mac_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .out_sum(out_sum_u), .out_beats(out_beats_u), .out_ovf(out_ovf_u)
  );

  vector_mac_stream #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_beats(out_beats_s), .out_ovf(out_ovf_s)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact dot products, wrapped into 16 bits after each beat.
  initial begin
    int acc_u, acc_s, beats_m, su, ss, ua, ub, sa, sb;
    bit ovf_u, ovf_s;
    res_t r;
    acc_u = 0; acc_s = 0; beats_m = 0; ovf_u = 0; ovf_s = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q_u.delete(); q_s.delete();
        acc_u = 0; acc_s = 0; beats_m = 0; ovf_u = 0; ovf_s = 0;
      end else begin
        if (out_valid_u && out_ready && q_u.size() != 0) void'(q_u.pop_front());
        if (out_valid_s && out_ready && q_s.size() != 0) void'(q_s.pop_front());
        if (in_valid && in_ready_u) begin
          su = 0; ss = 0;
          for (int l = 0; l < 4; l++) begin
            ua = int'((in_a >> (4 * l)) & 16'hF);
            ub = int'((in_b >> (4 * l)) & 16'hF);
            sa = (ua >= 8) ? ua - 16 : ua;
            sb = (ub >= 8) ? ub - 16 : ub;
            su += ua * ub;
            ss += sa * sb;
          end
          acc_u += su;
          if (acc_u >= 65536) begin acc_u -= 65536; ovf_u = 1; end
          acc_s += ss;
          if (acc_s > 32767) begin acc_s -= 65536; ovf_s = 1; end
          else if (acc_s < -32768) begin acc_s += 65536; ovf_s = 1; end
          beats_m = (beats_m == 255) ? 255 : beats_m + 1;
          if (in_last) begin
            r.sum = 16'(acc_u); r.beats = 8'(beats_m); r.ovf = ovf_u;
            q_u.push_back(r);
            r.sum = 16'(acc_s); r.ovf = ovf_s;
            q_s.push_back(r);
            acc_u = 0; acc_s = 0; beats_m = 0; ovf_u = 0; ovf_s = 0;
          end
        end
      end
    end
  end

  // Compare process: any valid output must match the oldest pending result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_valid_u", out_valid_u, 0);
        chk("rst_valid_s", out_valid_s, 0);
      end else begin
        if (out_valid_u) begin
          chk("pending_u", q_u.size() != 0, 1);
          if (q_u.size() != 0) begin
            chk("sum_u", out_sum_u, q_u[0].sum);
            chk("beats_u", out_beats_u, q_u[0].beats);
            chk("ovf_u", out_ovf_u, q_u[0].ovf);
          end
        end
        if (out_valid_s) begin
          chk("pending_s", q_s.size() != 0, 1);
          if (q_s.size() != 0) begin
            chk("sum_s", out_sum_s, q_s[0].sum);
            chk("beats_s", out_beats_s, q_s[0].beats);
            chk("ovf_s", out_ovf_s, q_s[0].ovf);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    #1;
    n = 0;
    while (!in_ready_u && n < 100) begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n++;
    end
    if (n >= 100) chk("accept_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_last = 1'($urandom);
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    @(negedge clk);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid_u && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("result_timeout", n, 0);
  endtask

  initial begin
    int n;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid_u, 0);
    chk("reset_out_sum", out_sum_u, 0);
    chk("reset_out_beats", out_beats_u, 0);
    chk("reset_out_ovf", out_ovf_u, 0);
    chk("reset_in_ready", in_ready_u, 1);
    @(negedge clk);

    // Single beat: 1*5+2*6+3*7+4*8 = 70, result visible after the second edge.
    send(16'h4321, 16'h8765, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("t1_latency", n, 2);
    chk("t1_sum", out_sum_u, 70);
    chk("t1_beats", out_beats_u, 1);
    chk("t1_ovf", out_ovf_u, 0);
    chk("t1_sum_signed", out_sum_s, 6);
    @(negedge clk);

    // Two beats: 900 + 8 = 908, then a fresh vector starts from zero.
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'h1111, 16'h2222, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("t2_sum", out_sum_u, 908);
    chk("t2_beats", out_beats_u, 2);
    chk("t2_sum_signed", out_sum_s, 12);
    @(negedge clk);
    send(16'h1111, 16'h1111, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("t2_next_sum", out_sum_u, 4);
    chk("t2_next_beats", out_beats_u, 1);
    @(negedge clk);

    // Backpressure: three results of 10, 20, 30 queue up behind a blocked consumer.
    out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b1);
    send(16'h4321, 16'h2222, 1'b1);
    send(16'h4321, 16'h3333, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("bp_in_ready", in_ready_u, 0);
    chk("bp_valid", out_valid_u, 1);
    chk("bp_sum0", out_sum_u, 10);
    repeat (3) @(negedge clk);
    chk("bp_hold", out_sum_u, 10);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_sum1", out_sum_u, 20);
    @(negedge clk);
    chk("bp_sum2", out_sum_u, 30);
    @(negedge clk);
    chk("bp_drained", out_valid_u, 0);

    // Overflow: 73 * 900 = 65700 wraps to 164.
    repeat (72) send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("ovf_sum", out_sum_u, 164);
    chk("ovf_flag", out_ovf_u, 1);
    chk("ovf_beats", out_beats_u, 73);
    chk("ovf_sum_signed", out_sum_s, 292);
    chk("ovf_flag_signed", out_ovf_s, 0);
    @(negedge clk);
    send(16'h1111, 16'h1111, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("ovf_cleared", out_ovf_u, 0);
    chk("ovf_next_sum", out_sum_u, 4);
    @(negedge clk);

    // Beat counter saturates at all-ones.
    repeat (259) send(16'h0000, 16'h0000, 1'b0);
    send(16'h0000, 16'h0000, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("sat_beats", out_beats_u, 255);
    chk("sat_sum", out_sum_u, 0);
    @(negedge clk);

    // Signed operands.
    send(16'h8888, 16'h8888, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("s_neg8sq", out_sum_s, 256);
    chk("s_neg8sq_unsigned", out_sum_u, 256);
    @(negedge clk);
    send(16'h1078, 16'hF377, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("s_mixed", out_sum_s, 16'hFFF8);
    chk("s_mixed_unsigned", out_sum_u, 120);
    @(negedge clk);

    // Reset mid-vector discards the partial sum.
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(16'h1111, 16'h1111, 1'b1);
    in_valid = 1'b0;
    wait_out(n);
    chk("rst_mid_sum", out_sum_u, 4);
    chk("rst_mid_beats", out_beats_u, 1);
    @(negedge clk);

    // Random stream with random gaps and random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
    end
    send(16'($urandom), 16'($urandom), 1'b1);
    rand_rdy = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("final_q_u_empty", q_u.size(), 0);
    chk("final_q_s_empty", q_s.size(), 0);
    chk("final_valid", out_valid_u, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
